if_id_fetch_buf: RTL

//  Decoupling buffer between the instruction fetch stage (pc/inst producer) and the decode stage.

---
 rtl/ysyx_pkg.sv | 37 +++
 rtl/if_id_fetch_buf_fifo_ptr_ctrl.sv | 66 ++++++
 rtl/if_id_fetch_buf.sv | 94 +++++++++
 3 files changed

// File: rtl/ysyx_pkg.sv
// Shared fetch/decode definitions: control-transfer opcodes, fetch entry
// layout and the predecode helper used when an instruction is buffered.
package ysyx_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int unsigned FETCH_XLEN = 32;

  // Entry layout {is_ctrl, pc, inst} at the default datapath width.
  typedef struct packed {
    logic                  is_ctrl;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

  // Width of one fetch entry for an arbitrary datapath width.
  function automatic int fetch_entry_w(input int xlen);
    return 2 * xlen + 1;
  endfunction

  // True when the opcode can redirect the instruction stream.
  function automatic logic is_ctrl_op(input logic [6:0] opcode);
    logic hit;
    case (opcode)
      OP_JAL:    hit = 1'b1;
      OP_JALR:   hit = 1'b1;
      OP_BRANCH: hit = 1'b1;
      OP_SYSTEM: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/if_id_fetch_buf_fifo_ptr_ctrl.sv
// Read/write pointers and occupancy count for a power-of-two FIFO.
// Flush returns everything to the empty state on the next edge.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Never advance past full or below empty, whatever the caller asks.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer and count update; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign wr_ptr = wr_ptr_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;
  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/if_id_fetch_buf.sv
// IF/ID decoupling buffer: FIFO of {pc, inst} pairs tagged with a
// control-transfer predecode bit, cleared as a whole on redirect.
module if_id_fetch_buf #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic                     out_is_ctrl,
  output logic [$clog2(DEPTH):0]   occupancy
);

  import ysyx_pkg::*;

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = fetch_entry_w(XLEN);

  logic [PTR_W-1:0]   wr_ptr_s;
  logic [PTR_W-1:0]   rd_ptr_s;
  logic [CNT_W-1:0]   count_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [ENTRY_W-2:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0]   ctrl_bits_r;
  logic [ENTRY_W-1:0] head_entry_s;

  assign in_ready  = ~full_s;
  assign out_valid = ~empty_s;
  assign occupancy = count_s;
  assign push_s    = in_valid & ~full_s & ~flush;
  assign pop_s     = ~empty_s & out_ready & ~flush;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_s),
    .pop    (pop_s),
    .flush  (flush),
    .wr_ptr (wr_ptr_s),
    .rd_ptr (rd_ptr_s),
    .count  (count_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  // Capture pc/inst into the write slot; contents are masked until valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_s] <= {in_pc, in_inst};
    end
  end

  // Predecode the opcode once at push and keep the tag with the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_bits_r <= {DEPTH{1'b0}};
    end else if (push_s) begin
      ctrl_bits_r[wr_ptr_s] <= is_ctrl_op(in_inst[6:0]);
    end else begin
      ctrl_bits_r <= ctrl_bits_r;
    end
  end

  assign head_entry_s = {ctrl_bits_r[rd_ptr_s], data_mem_r[rd_ptr_s]};

  // Present the head entry, forcing zeros while the buffer is empty.
  always_comb begin
    out_pc      = {XLEN{1'b0}};
    out_inst    = {XLEN{1'b0}};
    out_is_ctrl = 1'b0;
    if (out_valid) begin
      out_is_ctrl = head_entry_s[2*XLEN];
      out_pc      = head_entry_s[2*XLEN-1:XLEN];
      out_inst    = head_entry_s[XLEN-1:0];
    end else begin
      out_is_ctrl = 1'b0;
    end
  end

endmodule
